// File: rtl/pipe_stage_skid.sv
// Two-entry valid/ready pipeline stage with a skid buffer.
// The main entry drives the outputs; the skid entry catches the one
// instruction accepted while the downstream stage stalls. in_ready and
// out_valid are registered, so there is no combinational path from
// out_ready to in_ready. Idle cycles with a ready consumer are counted.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [15:0]       bubble_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    // A bubble is presented as a NOP; the payload keeps its last value.
    assign out_ctrl   = out_valid_q ? main_ctrl : '0;
    assign out_data   = main_data;
    assign bubble_cnt = bubble_q;

    // Occupancy FSM with entry storage and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl   <= '0;
            main_data   <= '0;
            skid_ctrl   <= '0;
            skid_data   <= '0;
        end else if (flush) begin
            // Squash everything held and anything accepted this cycle;
            // main_data is kept so out_data holds its last value.
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl   <= in_ctrl;
                        main_data   <= in_data;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_fire) begin
                        skid_ctrl   <= in_ctrl;
                        skid_data   <= in_data;
                        state       <= TWO;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_ctrl   <= skid_ctrl;
                        main_data   <= skid_data;
                        state       <= ONE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles where the consumer was ready but idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (!out_valid_q && out_ready && (bubble_q != 16'hFFFF)) begin
            bubble_q <= bubble_q + 16'd1;
        end
    end

endmodule
